// File: rtl/vga_sync_decoder_if.sv
// Sync stream (pixel strobe, hsync, vsync) into vga_sync_decoder and the
// recovered timing it produces; the source drives master, the decoder is slave.
interface vga_sync_decoder_if;
  logic       p_tick;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       locked;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output p_tick, hsync, vsync,
    input  x, y, video_on, locked, frame_start, sync_err
  );

  modport slave (
    input  p_tick, hsync, vsync,
    output x, y, video_on, locked, frame_start, sync_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from an hsync/vsync stream and tracks lock.
// Optional macro VGA_SYNC_WATCHDOG_EN adds a stalled-hsync watchdog.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned H_SYNC_X  = 656,
  parameter int unsigned V_SYNC_Y  = 513,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_DISPLAY = 480
) (
  input logic               clk,
  input logic               reset,
  vga_sync_decoder_if.slave vga
);
  typedef enum logic [2:0] {
    UNLOCKED = 3'd0,
    H_ACQ    = 3'd1,
    H_LOCK   = 3'd2,
    V_ACQ    = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC = 10'(H_SYNC_X);
  localparam logic [9:0] V_SYNC = 10'(V_SYNC_Y);
  localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP = 10'(V_DISPLAY);

  state_t     state_r;
  state_t     state_next_s;
  logic [9:0] x_r;
  logic [9:0] y_r;
  logic [9:0] x_next_s;
  logic [9:0] y_next_s;
  logic [9:0] x_new_s;
  logic [9:0] y_new_s;
  logic       hs_d_r;
  logic       vs_d_r;
  logic       hs_rise_s;
  logic       vs_rise_s;
  logic       h_ok_s;
  logic       v_ok_s;
  logic       h_fail_s;
  logic       wd_fire_s;
  logic       zero_tick_r;
  logic       frame_start_r;
  logic       sync_err_r;
  logic       locked_s;
  logic       err_set_s;

  assign hs_rise_s = vga.p_tick & vga.hsync & ~hs_d_r;
  assign vs_rise_s = vga.p_tick & vga.vsync & ~vs_d_r;

  // Free-running successor of the current position
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (x_r == H_LAST) begin
      x_next_s = 10'd0;
      if (y_r == V_LAST) begin
        y_next_s = 10'd0;
      end else begin
        y_next_s = y_r + 10'd1;
      end
    end else begin
      x_next_s = x_r + 10'd1;
    end
  end

  // Sync edges must land exactly where the free-running count predicts
  assign h_ok_s = (x_next_s == H_SYNC);
  assign v_ok_s = (y_next_s == V_SYNC);

`ifdef VGA_SYNC_WATCHDOG_EN
  localparam logic [10:0] WD_LIMIT = 11'd1024;
  logic [10:0] wd_cnt_r;

  // Ticks since the last hsync rise, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= 11'd0;
    end else if (hs_rise_s) begin
      wd_cnt_r <= 11'd0;
    end else if (vga.p_tick && (wd_cnt_r != WD_LIMIT)) begin
      wd_cnt_r <= wd_cnt_r + 11'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign wd_fire_s = vga.p_tick & ~hs_rise_s & (wd_cnt_r == (WD_LIMIT - 11'd1))
                   & (state_r != UNLOCKED);
`else
  assign wd_fire_s = 1'b0;
`endif

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= UNLOCKED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: hsync check first; a failed hsync check masks a coincident vsync rise
  always_comb begin
    state_next_s = state_r;
    h_fail_s     = 1'b0;
    if (wd_fire_s) begin
      state_next_s = UNLOCKED;
    end else if (vga.p_tick) begin
      if (hs_rise_s) begin
        case (state_r)
          UNLOCKED: state_next_s = H_ACQ;
          H_ACQ:    state_next_s = h_ok_s ? H_LOCK : H_ACQ;
          H_LOCK, V_ACQ, LOCKED: begin
            if (!h_ok_s) begin
              state_next_s = UNLOCKED;
              h_fail_s     = 1'b1;
            end else begin
              state_next_s = state_r;
            end
          end
          default:  state_next_s = UNLOCKED;
        endcase
      end else begin
        state_next_s = state_r;
      end
      if (vs_rise_s && !h_fail_s) begin
        case (state_r)
          H_LOCK:  state_next_s = V_ACQ;
          V_ACQ:   state_next_s = v_ok_s ? LOCKED : V_ACQ;
          LOCKED:  state_next_s = v_ok_s ? LOCKED : UNLOCKED;
          default: state_next_s = state_next_s;
        endcase
      end else begin
        state_next_s = state_next_s;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // State-derived outputs: lock flag and loss-of-lock event
  always_comb begin
    locked_s  = (state_r == LOCKED);
    err_set_s = (state_r != UNLOCKED) && (state_next_s == UNLOCKED);
  end

  // Position update; y only runs once horizontal lock is established
  always_comb begin
    x_new_s = x_r;
    y_new_s = y_r;
    if (wd_fire_s) begin
      x_new_s = 10'd0;
      y_new_s = 10'd0;
    end else if (vga.p_tick) begin
      x_new_s = hs_rise_s ? H_SYNC : x_next_s;
      case (state_r)
        H_LOCK, V_ACQ, LOCKED: y_new_s = vs_rise_s ? V_SYNC : y_next_s;
        default:               y_new_s = 10'd0;
      endcase
    end else begin
      x_new_s = x_r;
      y_new_s = y_r;
    end
  end

  // Datapath registers and one-clk event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      hs_d_r        <= 1'b0;
      vs_d_r        <= 1'b0;
      zero_tick_r   <= 1'b0;
      frame_start_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      x_r <= x_new_s;
      y_r <= y_new_s;
      if (vga.p_tick) begin
        hs_d_r <= vga.hsync;
        vs_d_r <= vga.vsync;
      end else begin
        hs_d_r <= hs_d_r;
        vs_d_r <= vs_d_r;
      end
      zero_tick_r   <= vga.p_tick & (x_new_s == 10'd0) & (y_new_s == 10'd0);
      frame_start_r <= zero_tick_r & locked_s;
      sync_err_r    <= err_set_s;
    end
  end

  assign vga.x           = x_r;
  assign vga.y           = y_r;
  assign vga.locked      = locked_s;
  assign vga.video_on    = locked_s & (x_r < H_DISP) & (y_r < V_DISP);
  assign vga.frame_start = frame_start_r;
  assign vga.sync_err    = sync_err_r;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboarded bench for vga_sync_decoder on a reduced frame geometry, with a
// tick-level sync generator, a reference model and directed scenario checks.
module tb_vga_sync_decoder;
  localparam int HT  = 40;
  localparam int HSX = 34;
  localparam int HSW = 4;
  localparam int HD  = 32;
  localparam int VT  = 20;
  localparam int VSY = 17;
  localparam int VD  = 15;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset;

  vga_sync_decoder_if vif();

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_X(HSX), .V_SYNC_Y(VSY),
    .H_DISPLAY(HD), .V_DISPLAY(VD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       lk;
    logic       vo;
    logic       fs;
    logic       er;
  } obs_t;

  obs_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model: lock progress 0=unlocked,1=h acquire,2=h locked,3=v acquire,4=locked
  int m_lvl, mx, my, m_wd;
  bit m_phs, m_pvs, m_zt;

  // generator state
  int gx, gy, vs_off;
  bit extra_pend, hs_mask, vs_mask, rand_gap, chk_hx;
  bit g_hs_prev, g_vs_prev;
  int hs_rises, vs_rises, err_cnt, fs_cnt;

  function automatic void model_step(input bit p, input bit h, input bit v, input bit r);
    obs_t e;
    bit hr, vr, hok, vok, fire, hfail;
    int xn, yn, old, lvl, nx, ny;
    e = '0;
    if (r) begin
      m_lvl = 0; mx = 0; my = 0; m_wd = 0;
      m_phs = 0; m_pvs = 0; m_zt = 0;
    end else begin
      e.fs = m_zt && (m_lvl == 4);
      m_zt = 0;
      if (p) begin
        hr = h && !m_phs;
        vr = v && !m_pvs;
        xn = (mx + 1) % HT;
        yn = (xn == 0) ? (my + 1) % VT : my;
        hok = (xn == HSX);
        vok = (yn == VSY);
        fire = 0;
`ifdef VGA_SYNC_WATCHDOG_EN
        if (hr) m_wd = 0;
        else if (m_wd < 1024) begin
          m_wd++;
          fire = (m_wd == 1024) && (m_lvl != 0);
        end
`endif
        old = m_lvl;
        lvl = old;
        hfail = 0;
        if (fire) begin
          lvl = 0; nx = 0; ny = 0;
        end else begin
          nx = hr ? HSX : xn;
          ny = (old >= 2) ? (vr ? VSY : yn) : 0;
          if (hr) begin
            if (old == 0) lvl = 1;
            else if (old == 1) lvl = hok ? 2 : 1;
            else if (!hok) begin lvl = 0; hfail = 1; end
          end
          if (vr && !hfail) begin
            if (old == 2) lvl = 3;
            else if (old == 3) lvl = vok ? 4 : 3;
            else if (old == 4 && !vok) lvl = 0;
          end
        end
        e.er = (old != 0) && (lvl == 0);
        m_zt = (nx == 0) && (ny == 0);
        mx = nx; my = ny; m_lvl = lvl;
        m_phs = h; m_pvs = v;
      end
    end
    e.x  = 10'(mx);
    e.y  = 10'(my);
    e.lk = (m_lvl == 4);
    e.vo = e.lk && (mx < HD) && (my < VD);
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clk_cycle(input bit p, input bit r);
    vif.p_tick = p;
    reset = r;
    model_step(p, vif.hsync, vif.vsync, r);
    @(posedge clk);
    #1;
    if (vif.sync_err === 1'b1) err_cnt++;
    if (vif.frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic tick();
    bit rose;
    int gap;
    if (extra_pend && gx == HT - 1) begin
      extra_pend = 0;
    end else begin
      gx++;
      if (gx == HT) begin
        gx = 0;
        gy = (gy + 1) % VT;
      end
    end
    vif.hsync = (!hs_mask && gx >= HSX && gx < HSX + HSW);
    vif.vsync = (!vs_mask && gy >= VSY + vs_off && gy < VSY + vs_off + 2);
    rose = vif.hsync && !g_hs_prev;
    if (rose) hs_rises++;
    if (vif.vsync && !g_vs_prev) vs_rises++;
    g_hs_prev = vif.hsync;
    g_vs_prev = vif.vsync;
    clk_cycle(1'b1, 1'b0);
    if (rose && chk_hx) chk("x_at_hsync_rise", int'(vif.x), HSX);
    gap = rand_gap ? $urandom_range(0, 2) : 1;
    repeat (gap) clk_cycle(1'b0, 1'b0);
  endtask

  task automatic wait_locked(input string name, input int budget);
    int n = 0;
    while (vif.locked !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(vif.locked === 1'b1), 1);
  endtask

  task automatic wait_pos(input int px, input int py, input int budget);
    int n = 0;
    while (!(gx == px && gy == py) && n < budget) begin
      tick();
      n++;
    end
    chk("generator_position_reached", int'(gx == px && gy == py), 1);
  endtask

  // Scoreboard monitor: one expectation per clock, compared mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        obs_t e;
        obs_t a;
        e = sb.pop_front();
        a = {vif.x, vif.y, vif.locked, vif.video_on, vif.frame_start, vif.sync_err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard: got x=%0d y=%0d locked=%b video_on=%b frame_start=%b sync_err=%b, expected x=%0d y=%0d locked=%b video_on=%b frame_start=%b sync_err=%b",
                   a.x, a.y, a.lk, a.vo, a.fs, a.er, e.x, e.y, e.lk, e.vo, e.fs, e.er);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: time limit reached before the end of the scenarios");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    vif.p_tick = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0; reset = 1'b1;
    extra_pend = 0; hs_mask = 0; vs_mask = 0; vs_off = 0; rand_gap = 0; chk_hx = 0;
    g_hs_prev = 0; g_vs_prev = 0; hs_rises = 0; vs_rises = 0; err_cnt = 0; fs_cnt = 0;

    // reset state
    repeat (3) clk_cycle(1'($urandom_range(0, 1)), 1'b1);
    chk("reset_x", int'(vif.x), 0);
    chk("reset_y", int'(vif.y), 0);
    chk("reset_locked", int'(vif.locked), 0);
    chk("reset_video_on", int'(vif.video_on), 0);
    chk("reset_sync_err", int'(vif.sync_err), 0);

    // nominal acquisition, p_tick every second clock
    gx = $urandom_range(0, 30);
    gy = 0;
    chk_hx = 1;
    wait_locked("initial_lock", 3 * FRAME);
    chk("lock_after_two_vsync_rises", vs_rises, 2);
    chk("lock_needs_two_hsync_rises", int'(hs_rises >= 2), 1);
    chk("locked_x_aligned", int'(vif.x), gx);
    chk("locked_y_aligned", int'(vif.y), gy);

    // one frame_start per frame, no errors while locked
    fs_cnt = 0; err_cnt = 0;
    repeat (3 * FRAME) tick();
    chk("frame_start_count_3_frames", fs_cnt, 3);
    chk("no_sync_err_while_locked", err_cnt, 0);

    // p_tick held low mid-line
    wait_pos(15, 5, 2 * FRAME);
    repeat (50) clk_cycle(1'b0, 1'b0);
    chk("pause_x_held", int'(vif.x), gx);
    chk("pause_y_held", int'(vif.y), gy);
    chk("pause_locked_held", int'(vif.locked), 1);

    // one long line while locked
    rand_gap = 1;
    wait_pos(0, 2, 2 * FRAME);
    extra_pend = 1; err_cnt = 0;
    wait_pos(0, 4, 2 * FRAME);
    chk("long_line_sync_err_pulses", err_cnt, 1);
    chk("long_line_locked", int'(vif.locked), 0);
    chk("long_line_video_on", int'(vif.video_on), 0);
    vs_rises = 0;
    wait_locked("relock_after_long_line", 3 * FRAME);
    chk("relock_after_two_vsync_rises", vs_rises, 2);

    // vsync one line late while locked
    wait_pos(0, 0, 2 * FRAME);
    vs_off = 1; err_cnt = 0;
    wait_pos(0, VSY + 2, 2 * FRAME);
    chk("late_vsync_sync_err_pulses", err_cnt, 1);
    chk("late_vsync_locked", int'(vif.locked), 0);
    wait_pos(0, 0, 2 * FRAME);
    vs_off = 0;
    wait_locked("relock_after_late_vsync", 3 * FRAME);

    // reset mid-frame while locked
    wait_pos(20, 10, 2 * FRAME);
    err_cnt = 0;
    clk_cycle(1'($urandom_range(0, 1)), 1'b1);
    g_hs_prev = 0; g_vs_prev = 0;
    chk("midreset_x", int'(vif.x), 0);
    chk("midreset_y", int'(vif.y), 0);
    chk("midreset_locked", int'(vif.locked), 0);
    chk("midreset_video_on", int'(vif.video_on), 0);
    chk("midreset_frame_start", int'(vif.frame_start), 0);
    repeat (HT) tick();
    chk("midreset_no_sync_err", err_cnt, 0);
    wait_locked("relock_after_reset", 3 * FRAME);

    // hsync stalled in H_LOCK
    clk_cycle(1'b0, 1'b1);
    g_hs_prev = 0; g_vs_prev = 0;
    n = 0;
    while (m_lvl != 2 && n < 4 * HT) begin
      tick();
      n++;
    end
    chk("reached_h_lock_before_stall", int'(m_lvl == 2 && vif.locked === 1'b0), 1);
    hs_mask = 1; vs_mask = 1; err_cnt = 0;
    repeat (1100) tick();
`ifdef VGA_SYNC_WATCHDOG_EN
    chk("watchdog_sync_err_pulses", err_cnt, 1);
    chk("watchdog_y_cleared", int'(vif.y), 0);
`else
    chk("stall_no_sync_err", err_cnt, 0);
`endif
    chk("stall_locked", int'(vif.locked), 0);
    wait_pos(0, 0, 2 * FRAME);
    hs_mask = 0; vs_mask = 0;
    wait_locked("relock_after_stall", 4 * FRAME);
    repeat (20) tick();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: p_tick  input  1  pixel-enable strobe; all counting and sampling only on cycles with p_tick=1.
REQ-004 SHALL have port: hsync  input  1  horizontal sync, active-high during retrace.
REQ-005 SHALL have port: vsync  input  1  vertical sync, active-high during retrace.
REQ-006 SHALL have port: x  output  10  recovered pixel column, 0..799.
REQ-007 SHALL have port: y  output  10  recovered line, 0..524.
REQ-008 SHALL have port: video_on  output  1  active-area flag.
REQ-009 SHALL have port: locked  output  1  high only in state LOCKED.
REQ-010 SHALL have port: frame_start  output  1  one-clk pulse at pixel (0,0) while locked.
REQ-011 SHALL have port: sync_err  output  1  one-clk pulse on loss of lock.
REQ-012 SHALL have parameters: H_TOTAL, default 800, ticks per line; V_TOTAL, default 525, lines per frame; H_SYNC_X, default 656, column at hsync rise; V_SYNC_Y, default 513, line at vsync rise; H_DISPLAY, default 640, active columns; V_DISPLAY, default 480, active lines.

Function
REQ-013 SHALL register hsync/vsync into hs_d/vs_d on p_tick only; rise = input 1 and delayed copy 0 on the same p_tick.
REQ-014 SHALL compute x_next = (x==H_TOTAL-1) ? 0 : x+1 and y_next = y, or (y==V_TOTAL-1 ? 0 : y+1) when x wraps.
REQ-015 SHALL load x<=H_SYNC_X on an hsync rise tick, otherwise x<=x_next on each p_tick; x and y hold when p_tick=0.
REQ-016 SHALL load y<=V_SYNC_Y on a vsync rise tick in states H_LOCK, V_ACQ, LOCKED, otherwise y<=y_next; y held at 0 in UNLOCKED and H_ACQ.
REQ-017 SHALL define h_ok = (x_next==H_SYNC_X) and v_ok = (y_next==V_SYNC_Y), both evaluated on the rise tick before loading.
REQ-018 SHALL implement FSM states UNLOCKED, H_ACQ, H_LOCK, V_ACQ, LOCKED.
REQ-019 SHALL transition on hsync rise: UNLOCKED->H_ACQ; H_ACQ->H_LOCK if h_ok, else stay H_ACQ; H_LOCK/V_ACQ/LOCKED->UNLOCKED if !h_ok.
REQ-020 SHALL transition on vsync rise: H_LOCK->V_ACQ; V_ACQ->LOCKED if v_ok, else stay V_ACQ; LOCKED->UNLOCKED if !v_ok.
REQ-021 SHALL resolve simultaneous hsync and vsync rise with the hsync check first; an hsync failure wins and the vsync rise is ignored.
REQ-022 SHALL pulse sync_err for exactly one clk on every transition into UNLOCKED from H_LOCK, V_ACQ or LOCKED; not on H_ACQ mismatches.
REQ-023 SHALL drive video_on = locked & (x<H_DISPLAY) & (y<V_DISPLAY), combinational from registered x, y and state.
REQ-024 SHALL pulse frame_start for one clk, the clk after x and y both become 0 while state is LOCKED.
REQ-025 SHALL use 10-bit x/y arithmetic with wrap at H_TOTAL-1 and V_TOTAL-1, never at 1023.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, set state=UNLOCKED, x=0, y=0, hs_d=0, vs_d=0, locked=0, frame_start=0, sync_err=0, video_on=0, regardless of p_tick.
REQ-027 SHALL treat reset mid-frame as full loss of state with no sync_err pulse; reacquisition starts at the next hsync rise.

Configuration
REQ-028 SHALL, with macro VGA_SYNC_WATCHDOG_EN defined, include an 11-bit p_tick counter cleared on each hsync rise; reaching 1024 in any state except UNLOCKED forces UNLOCKED, pulses sync_err, and clears x and y.
REQ-029 SHALL, without VGA_SYNC_WATCHDOG_EN, omit the counter; a stalled hsync leaves state unchanged.

Verification
REQ-030 SHALL cover nominal 640x480 sync stream, p_tick every 2nd clk -> locked=1 after 2 hsync rises plus 2 vsync rises; at the tick where hsync rises, x=656; frame_start once per 420000 ticks.
REQ-031 SHALL cover one line of 801 ticks while LOCKED -> sync_err 1 clk, locked=0, video_on=0, relock after 2 good lines and 2 good frames.
REQ-032 SHALL cover vsync rise at line 514 instead of 513 while LOCKED -> sync_err pulse, state UNLOCKED.
REQ-033 SHALL cover reset asserted at x=300,y=200 while LOCKED -> next clk all outputs 0, sync_err stays 0.
REQ-034 SHALL cover hsync held low for 1100 ticks in H_LOCK -> with VGA_SYNC_WATCHDOG_EN, sync_err pulse at tick 1024 and UNLOCKED; without it, state remains H_LOCK.
REQ-035 SHALL cover p_tick held 0 for 50 clks mid-line -> x, y and state unchanged.
